// File: rtl/sal_bk_ctrl_pp_if.sv
// Request and scheduler handshake bundle for the SAL per-bank controller.
// master: address decoder / scheduler side. slave: bank controller side.
interface sal_bk_ctrl_pp_if #(
  parameter int unsigned RA_WIDTH = 14,
  parameter int unsigned CA_WIDTH = 10
) ();

  // Decoder request channel
  logic                req_valid;
  logic                req_wr;
  logic [RA_WIDTH-1:0] req_ra;
  logic [CA_WIDTH-1:0] req_ca;
  logic                req_ready;

  // Scheduler command requests and same-cycle grants
  logic                act_req;
  logic                rd_req;
  logic                wr_req;
  logic                pre_req;
  logic                ref_req;
  logic                act_gnt;
  logic                rd_gnt;
  logic                wr_gnt;
  logic                pre_gnt;
  logic                ref_gnt;
  logic [RA_WIDTH-1:0] sched_ra;
  logic [CA_WIDTH-1:0] sched_ca;

  modport master (
    output req_valid, req_wr, req_ra, req_ca,
    output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
    input  req_ready,
    input  act_req, rd_req, wr_req, pre_req, ref_req,
    input  sched_ra, sched_ca
  );

  modport slave (
    input  req_valid, req_wr, req_ra, req_ca,
    input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
    output req_ready,
    output act_req, rd_req, wr_req, pre_req, ref_req,
    output sched_ra, sched_ca
  );

endinterface

// File: rtl/sal_bk_ctrl_pp.sv
// Per-bank controller for the SAL DDR2 controller: tracks open row, enforces
// bank timing, applies open/close/idle-timeout page policy, preempts an open
// bank for refresh and caps row-hit streaks while a refresh is pending.
// Optional hit/miss/conflict statistics outputs: define SAL_BK_STATS_EN.
module sal_bk_ctrl_pp #(
  parameter int unsigned RA_WIDTH = 14,
  parameter int unsigned CA_WIDTH = 10,
  parameter int unsigned TW       = 6,
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned MAX_HITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sal_bk_ctrl_pp_if.slave      bus,
  input  logic [TW-1:0]        t_rcd_i,
  input  logic [TW-1:0]        t_rp_i,
  input  logic [TW-1:0]        t_ras_i,
  input  logic [TW-1:0]        t_rfc_i,
  input  logic [TW-1:0]        t_rtp_i,
  input  logic [TW-1:0]        t_wtp_i,
  input  logic [TW-1:0]        t_rc_i,
  input  logic [1:0]           page_policy_i,
  input  logic [IDLE_W-1:0]    idle_timeout_i,
  input  logic                 aref_req_i,
  output logic                 aref_gnt_o,
  output logic                 bank_open_o
`ifdef SAL_BK_STATS_EN
  ,
  output logic [31:0]          stat_hit_o,
  output logic [31:0]          stat_miss_o,
  output logic [31:0]          stat_conflict_o
`endif
);

  localparam int unsigned HIT_MAX = (MAX_HITS > 0) ? MAX_HITS : 1;
  localparam int unsigned HIT_W   = (HIT_MAX > 1) ? $clog2(HIT_MAX + 1) : 1;

  typedef enum logic {ST_CLOSED, ST_OPEN} state_e;

  state_e              state_q, state_d;
  logic [RA_WIDTH-1:0] cur_ra_q, cur_ra_d;
  logic [TW-1:0]       rcd_q, ras_q, rc_q, rp_q, rfc_q, rtp_q, wtp_q;
  logic [TW-1:0]       rcd_d, ras_d, rc_d, rp_d, rfc_d, rtp_d, wtp_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [HIT_W-1:0]    hit_q, hit_d;

  logic hit_pend_c, row_miss_c, pre_cond_c, hit_cap_c;
  logic act_c, rd_c, wr_c, pre_c, ref_c;
  logic act_fire_c, rd_fire_c, wr_fire_c, pre_fire_c, ref_fire_c;
  logic pol_close_c, pol_tmo_c;
  logic [CA_WIDTH-1:0] sched_ca_c;

  // Timer load value: a value of 0 behaves like 1
  function automatic logic [TW-1:0] t_load(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - TW'(1);
  endfunction

  // Saturating down-count toward "constraint met"
  function automatic logic [TW-1:0] t_dec(input logic [TW-1:0] c);
    return (c == '0) ? '0 : c - TW'(1);
  endfunction

  // Command selection and next state
  always_comb begin
    state_d     = state_q;
    act_c       = 1'b0;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    pre_c       = 1'b0;
    ref_c       = 1'b0;
    pre_cond_c  = 1'b0;
    pol_close_c = (page_policy_i == 2'b01);
    pol_tmo_c   = (page_policy_i == 2'b10);
    hit_pend_c  = bus.req_valid && (bus.req_ra == cur_ra_q);
    row_miss_c  = bus.req_valid && (bus.req_ra != cur_ra_q);
    hit_cap_c   = (MAX_HITS != 0) && (hit_q == HIT_W'(HIT_MAX));

    case (state_q)
      ST_CLOSED: begin
        if ((rp_q == '0) && (rfc_q == '0)) begin
          if (aref_req_i) begin
            ref_c = 1'b1;
          end else if (bus.req_valid && (rc_q == '0)) begin
            act_c = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        pre_cond_c = row_miss_c
                  || (aref_req_i && !hit_pend_c)
                  || (aref_req_i && hit_cap_c)
                  || (pol_close_c && !bus.req_valid)
                  || (pol_tmo_c && !bus.req_valid && (idle_q >= idle_timeout_i));
        if (pre_cond_c) begin
          pre_c = (ras_q == '0) && (rtp_q == '0) && (wtp_q == '0);
        end else if (hit_pend_c && (rcd_q == '0)) begin
          rd_c = !bus.req_wr;
          wr_c = bus.req_wr;
        end
      end
      default: ;
    endcase

    if (rst) begin
      act_c = 1'b0;
      rd_c  = 1'b0;
      wr_c  = 1'b0;
      pre_c = 1'b0;
      ref_c = 1'b0;
    end

    act_fire_c = act_c && bus.act_gnt;
    rd_fire_c  = rd_c  && bus.rd_gnt;
    wr_fire_c  = wr_c  && bus.wr_gnt;
    pre_fire_c = pre_c && bus.pre_gnt;
    ref_fire_c = ref_c && bus.ref_gnt;

    if (act_fire_c) state_d = ST_OPEN;
    if (pre_fire_c) state_d = ST_CLOSED;
  end

  // Timer, row, idle and hit-streak next values
  always_comb begin
    cur_ra_d = act_fire_c ? bus.req_ra : cur_ra_q;
    rcd_d    = act_fire_c ? t_load(t_rcd_i) : t_dec(rcd_q);
    ras_d    = act_fire_c ? t_load(t_ras_i) : t_dec(ras_q);
    rc_d     = act_fire_c ? t_load(t_rc_i)  : t_dec(rc_q);
    rp_d     = pre_fire_c ? t_load(t_rp_i)  : t_dec(rp_q);
    rfc_d    = ref_fire_c ? t_load(t_rfc_i) : t_dec(rfc_q);
    rtp_d    = rd_fire_c  ? t_load(t_rtp_i) : t_dec(rtp_q);
    wtp_d    = wr_fire_c  ? t_load(t_wtp_i) : t_dec(wtp_q);

    idle_d = '0;
    if ((state_d == state_q) && (state_q == ST_OPEN) && !bus.req_valid) begin
      idle_d = (idle_q == '1) ? idle_q : idle_q + IDLE_W'(1);
    end

    hit_d = hit_q;
    if (act_fire_c || pre_fire_c || !aref_req_i) begin
      hit_d = '0;
    end else if ((rd_fire_c || wr_fire_c) && (hit_q != HIT_W'(HIT_MAX))) begin
      hit_d = hit_q + HIT_W'(1);
    end
  end

  // State, timers and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_CLOSED;
      cur_ra_q <= '0;
      rcd_q    <= '0;
      ras_q    <= '0;
      rc_q     <= '0;
      rp_q     <= '0;
      rfc_q    <= '0;
      rtp_q    <= '0;
      wtp_q    <= '0;
      idle_q   <= '0;
      hit_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_ra_q <= cur_ra_d;
      rcd_q    <= rcd_d;
      ras_q    <= ras_d;
      rc_q     <= rc_d;
      rp_q     <= rp_d;
      rfc_q    <= rfc_d;
      rtp_q    <= rtp_d;
      wtp_q    <= wtp_d;
      idle_q   <= idle_d;
      hit_q    <= hit_d;
    end
  end

`ifdef SAL_BK_STATS_EN
  logic [31:0] stat_hit_q, stat_miss_q, stat_conflict_q;

  // Saturating hit / miss / conflict statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hit_q      <= '0;
      stat_miss_q     <= '0;
      stat_conflict_q <= '0;
    end else begin
      if ((rd_fire_c || wr_fire_c) && (stat_hit_q != '1)) stat_hit_q <= stat_hit_q + 32'd1;
      if (act_fire_c && (stat_miss_q != '1)) stat_miss_q <= stat_miss_q + 32'd1;
      if (pre_fire_c && row_miss_c && (stat_conflict_q != '1)) begin
        stat_conflict_q <= stat_conflict_q + 32'd1;
      end
    end
  end

  assign stat_hit_o      = stat_hit_q;
  assign stat_miss_o     = stat_miss_q;
  assign stat_conflict_o = stat_conflict_q;
`endif

  assign sched_ca_c    = bus.req_ca;
  assign bus.sched_ca  = sched_ca_c;
  assign bus.sched_ra  = bus.req_ra;
  assign bus.act_req   = act_c;
  assign bus.rd_req    = rd_c;
  assign bus.wr_req    = wr_c;
  assign bus.pre_req   = pre_c;
  assign bus.ref_req   = ref_c;
  assign bus.req_ready = rd_fire_c || wr_fire_c;
  assign aref_gnt_o    = ref_fire_c;
  assign bank_open_o   = (state_q == ST_OPEN);

  // Grants must only answer an asserted request; at most one request at a time
  a_act_gnt: assert property (@(posedge clk) disable iff (rst) bus.act_gnt |-> act_c);
  a_rd_gnt:  assert property (@(posedge clk) disable iff (rst) bus.rd_gnt  |-> rd_c);
  a_wr_gnt:  assert property (@(posedge clk) disable iff (rst) bus.wr_gnt  |-> wr_c);
  a_pre_gnt: assert property (@(posedge clk) disable iff (rst) bus.pre_gnt |-> pre_c);
  a_ref_gnt: assert property (@(posedge clk) disable iff (rst) bus.ref_gnt |-> ref_c);
  a_onehot:  assert property (@(posedge clk) disable iff (rst)
                              $onehot0({act_c, rd_c, wr_c, pre_c, ref_c}));

endmodule

// File: tb/tb_sal_bk_ctrl_pp.sv
// Scoreboard bench for sal_bk_ctrl_pp: the scheduler grants every request in
// the cycle it appears; stimulus queues hand-computed command events and a
// negedge monitor pops and compares them as the DUT raises requests.
module tb_sal_bk_ctrl_pp;

  localparam int unsigned RA_W   = 14;
  localparam int unsigned CA_W   = 10;
  localparam int unsigned TW     = 6;
  localparam int unsigned IDLE_W = 8;
  localparam int unsigned MAXH   = 2;

  // Event codes {act, rd, wr, pre, ref, req_ready, aref_gnt}
  localparam logic [6:0] EV_ACT = 7'b1000000;
  localparam logic [6:0] EV_RD  = 7'b0100010;
  localparam logic [6:0] EV_WR  = 7'b0010010;
  localparam logic [6:0] EV_PRE = 7'b0001000;
  localparam logic [6:0] EV_REF = 7'b0000101;

  typedef struct {
    logic [6:0]      code;
    int              cyc;
    logic [RA_W-1:0] ra;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic [TW-1:0] t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp, t_rc;
  logic [1:0] policy;
  logic [IDLE_W-1:0] idle_to;
  logic aref_req, aref_gnt, bank_open;

  ev_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int base = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sal_bk_ctrl_pp_if #(.RA_WIDTH(RA_W), .CA_WIDTH(CA_W)) bus ();

  assign bus.act_gnt = bus.act_req;
  assign bus.rd_gnt  = bus.rd_req;
  assign bus.wr_gnt  = bus.wr_req;
  assign bus.pre_gnt = bus.pre_req;
  assign bus.ref_gnt = bus.ref_req;

  sal_bk_ctrl_pp #(
    .RA_WIDTH(RA_W), .CA_WIDTH(CA_W), .TW(TW), .IDLE_W(IDLE_W), .MAX_HITS(MAXH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .t_rcd_i(t_rcd), .t_rp_i(t_rp), .t_ras_i(t_ras), .t_rfc_i(t_rfc),
    .t_rtp_i(t_rtp), .t_wtp_i(t_wtp), .t_rc_i(t_rc),
    .page_policy_i(policy), .idle_timeout_i(idle_to),
    .aref_req_i(aref_req), .aref_gnt_o(aref_gnt), .bank_open_o(bank_open)
  );

  function automatic logic [6:0] out_code();
    return {bus.act_req, bus.rd_req, bus.wr_req, bus.pre_req, bus.ref_req,
            bus.req_ready, aref_gnt};
  endfunction

  task automatic expect_ev(input logic [6:0] code, input int off, input logic [RA_W-1:0] ra);
    ev_t e;
    e.code = code;
    e.cyc  = base + off;
    e.ra   = ra;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to relative cycle off, landing 1 time unit after its clock edge
  task automatic goto(input int off);
    while (cyc < base + off) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every asserted request must match the head of the scoreboard
  always @(negedge clk) begin
    logic [6:0] code;
    ev_t e;
    code = out_code();
    if (code != 7'd0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: cyc=%0d code=%b, expected none", cyc - base, code);
      end else begin
        e = exp_q.pop_front();
        if (code !== e.code || cyc != e.cyc || (e.code[6] && bus.sched_ra !== e.ra)) begin
          miscompares++;
          $display("FAIL event: cyc=%0d code=%b ra=%0d, expected cyc=%0d code=%b ra=%0d",
                   cyc - base, code, bus.sched_ra, e.cyc - base, e.code, e.ra);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    t_rcd = 6'd4; t_ras = 6'd10; t_rp = 6'd3; t_rc = 6'd12;
    t_rfc = 6'd8; t_rtp = 6'd2; t_wtp = 6'd6;
    policy = 2'b00; idle_to = 8'd5; aref_req = 1'b0;
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_ra = 14'd5; bus.req_ca = 10'd0;
    rst = 1'b1;
    #2;
    check("reset_outputs", {24'd0, out_code(), bank_open}, 32'd0);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 base = cyc;
    check("closed_after_reset", {31'd0, bank_open}, 32'd0);

    // Open policy: ACT row 5 then RD once tRCD elapses
    expect_ev(EV_ACT, 0, 14'd5);
    expect_ev(EV_RD, 4, 14'd0);
    bus.req_valid = 1'b1; bus.req_ra = 14'd5; bus.req_ca = 10'd3;
    goto(5); bus.req_valid = 1'b0;
    goto(6); check("open_after_read", {31'd0, bank_open}, 32'd1);

    // Row miss: PRE held off by tRAS, ACT by tRP after PRE
    expect_ev(EV_PRE, 10, 14'd0);
    expect_ev(EV_ACT, 13, 14'd9);
    expect_ev(EV_RD, 17, 14'd0);
    bus.req_valid = 1'b1; bus.req_ra = 14'd9; bus.req_ca = 10'd1;

    // Close policy: single write, PRE exactly tWTP later
    goto(18);
    expect_ev(EV_WR, 18, 14'd0);
    expect_ev(EV_PRE, 24, 14'd0);
    policy = 2'b01; bus.req_wr = 1'b1; bus.req_ca = 10'd7;
    goto(19); bus.req_valid = 1'b0; bus.req_wr = 1'b0;
    goto(25); check("closed_after_close_pre", {31'd0, bank_open}, 32'd0);

    // Timeout policy: request on idle cycle 4 restarts the count
    goto(28);
    policy = 2'b10;
    expect_ev(EV_ACT, 28, 14'd2);
    expect_ev(EV_RD, 32, 14'd0);
    expect_ev(EV_RD, 37, 14'd0);
    expect_ev(EV_PRE, 43, 14'd0);
    bus.req_valid = 1'b1; bus.req_ra = 14'd2;
    goto(33); bus.req_valid = 1'b0;
    goto(37); bus.req_valid = 1'b1;
    goto(38); bus.req_valid = 1'b0;
    goto(44); policy = 2'b00;

    // Refresh preemption with hit cap of 2
    goto(47);
    expect_ev(EV_ACT, 47, 14'd4);
    expect_ev(EV_RD, 51, 14'd0);
    expect_ev(EV_RD, 52, 14'd0);
    expect_ev(EV_PRE, 57, 14'd0);
    expect_ev(EV_REF, 60, 14'd0);
    expect_ev(EV_ACT, 68, 14'd4);
    expect_ev(EV_RD, 72, 14'd0);
    bus.req_valid = 1'b1; bus.req_ra = 14'd4;
    goto(51); aref_req = 1'b1;
    goto(61); aref_req = 1'b0;
    goto(73); bus.req_valid = 1'b0;

    // Reset while open with tRAS mid-count
    goto(74);
    bus.req_valid = 1'b1; bus.req_ra = 14'd6;
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", {24'd0, out_code(), bank_open}, 32'd0);
    goto(76);
    rst = 1'b0;
    expect_ev(EV_ACT, 76, 14'd6);
    expect_ev(EV_RD, 80, 14'd0);
    goto(81); bus.req_valid = 1'b0;
    goto(85);
    check("open_after_reset_act", {31'd0, bank_open}, 32'd1);

    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event: got none, expected cyc=%0d code=%b", e.cyc - base, e.code);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
